mipi_dphy_ppi_pattern_gen: RTL and testbench
============================================

# mipi_dphy_ppi_pattern_gen

Synthesizable, parametrised PPI-side pattern source that replaces the fixed two-lane D-PHY RX simulation stub. It emits per-lane high-speed byte streams with proper SoT/EoT framing, selectable data patterns and configurable burst/gap lengths, all on one clock. It sits in place of the D-PHY RX PPI outputs and feeds the CSI-2 RX lane merger, for simulation and for on-board camera-less bring-up.

## Interface
- LANES, 2, number of data lanes (1..4)
- LEN_WIDTH, 16, width of burst/gap length fields
- core_clk  in  1  byte clock; all logic on rising edge
- core_rst  in  1  synchronous, active-high reset
- enable  in  1  level; start bursts / stop after current burst
- cfg_mode  in  2  0 up/down counter, 1 lane-offset counter, 2 fixed byte, 3 LFSR
- cfg_burst_len  in  LEN_WIDTH  payload bytes per lane per burst (0 treated as 1)
- cfg_gap_len  in  LEN_WIDTH  stop-state cycles between bursts
- cfg_seed  in  8  counter start / fixed byte / LFSR seed
- err_inject  in  1  one-cycle request to corrupt next SoT
- dl_rxdatahs  out  8*LANES  lane k at [8k+7:8k]
- dl_rxvalidhs, dl_rxactivehs, dl_rxsynchs, dl_stopstate, dl_errsoths  out  LANES each  per-lane PPI flags (all lanes identical)
- busy  out  1  high in any state but IDLE
- burst_count  out  16  completed bursts, wraps

## Operation
- FSM: IDLE -> SOT -> DATA -> EOT -> GAP -> (SOT if enable else IDLE).
- IDLE: stopstate=1, others 0; leaves to SOT on enable=1.
- SOT (1 cycle): activehs=1, synchs=1, validhs=1, data=0xB8 on every lane; latch cfg_mode, cfg_burst_len, cfg_gap_len, cfg_seed; load lane generators.
- DATA (burst_len cycles): activehs=1, validhs=1, one pattern byte per lane per cycle.
- EOT (1 cycle): activehs=0, validhs=0, stopstate=0; burst_count+1.
- GAP: stopstate=1 for gap_len cycles; gap_len=0 -> EOT goes directly to SOT/IDLE.
- Patterns (lane k, byte index i from 0): mode0 even lanes seed+i, odd lanes seed-i (mod 256); mode1 seed+i+k; mode2 seed constant; mode3 8-bit Galois LFSR poly x^8+x^6+x^5+x^4+1, lane seed = cfg_seed XOR k, seed 0 replaced by 0x01, advance once per DATA byte, first byte = seed.
- enable deassert mid-burst: burst completes normally, then IDLE after GAP.
- Config changes mid-burst ignored until next SOT.
- core_rst at any point: next cycle IDLE, outputs at reset values, burst_count=0, pending err_inject cleared.

## Timing
- All outputs registered; reset values: stopstate all 1, everything else 0.
- enable sampled high in IDLE at cycle n -> SOT outputs visible n+1, first DATA byte n+2.
- Burst occupancy: 1 + burst_len + 1 + gap_len cycles; back-to-back period identical.
- synchs and validhs coincide in SOT; validhs never high outside SOT/DATA.
- err_inject and SOT entry in same cycle: applies to that SOT.

## Configuration
- MIPI_DPHY_PPI_PATTERN_GEN_ERR_INJ_EN defined: err_inject arms a flag; next SOT sends 0xB9 instead of 0xB8 and asserts errsoths (all lanes) for that cycle only; flag clears.
- Undefined: err_inject ignored, errsoths tied 0, no flag register; ports remain.

## Structure
- Package mipi_dphy_ppi_pattern_pkg: state enum (IDLE/SOT/DATA/EOT/GAP), mode enum, SYNC_BYTE=8'hB8, SYNC_BYTE_ERR=8'hB9, LFSR tap constant.
- Sub-module mipi_dphy_ppi_pattern_lane, instantiated LANES times: load/step inputs, lane index parameter, 8-bit pattern output.
- Top holds FSM, length counters, burst_count, error flag, output registers.

## Test plan
- Reset, LANES=2, mode0, seed=0x10, burst_len=4, gap_len=2, enable=1 -> lane0 B8,10,11,12,13; lane1 B8,10,0F,0E,0D; period 8 cycles.
- LANES=4, mode1, seed=0xFE, burst_len=3 -> lane3 bytes B8,01,02,03 (wrap mod 256).
- Mode3, seed=0x00 -> lane0 first byte 0x01, sequence matches reference LFSR model for 300 bytes.
- enable dropped at 2nd DATA byte of burst_len=8 -> all 8 bytes sent, EOT, GAP, IDLE; burst_count=1.
- burst_len=0, gap_len=0, continuous -> 1 data byte, period 3 cycles, stopstate never high between bursts.
- With ERR_INJ_EN, err_inject pulse in GAP -> next SOT carries 0xB9 and errsoths=1 one cycle; following SOT clean; core_rst mid-DATA -> next cycle stopstate=1, busy=0.

Source files
------------

// File: rtl/mipi_dphy_ppi_pattern_pkg.sv
// Shared types and constants for the PPI-side D-PHY pattern source.
// Covers the sequencer states, the pattern modes, the sync bytes and the lane LFSR step.
package mipi_dphy_ppi_pattern_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SOT  = 3'd1,
      DATA = 3'd2,
      EOT  = 3'd3,
      GAP  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      MODE_UPDOWN = 2'd0,
      MODE_OFFSET = 2'd1,
      MODE_FIXED  = 2'd2,
      MODE_LFSR   = 2'd3
   } mode_t;

   localparam logic [7:0] SYNC_BYTE     = 8'hB8;
   localparam logic [7:0] SYNC_BYTE_ERR = 8'hB9;
   // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
   localparam logic [7:0] LFSR_TAPS     = 8'hB8;

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {1'b0, v[7:1]} ^ (v[0] ? LFSR_TAPS : 8'h00);
   endfunction

endpackage

// File: rtl/mipi_dphy_ppi_pattern_lane.sv
// One lane's byte generator. On load it captures the mode and seeds its value.
// On step it advances to the next payload byte; the output is always the current byte.
module mipi_dphy_ppi_pattern_lane
   import mipi_dphy_ppi_pattern_pkg::*;
#(
   parameter int LANE_IDX = 0
)
(
   input  logic       core_clk,
   input  logic       core_rst,
   input  logic       i_load,
   input  logic       i_step,
   input  logic [1:0] i_mode,
   input  logic [7:0] i_seed,
   output logic [7:0] o_pattern
);

   localparam logic [7:0] IDX = 8'(LANE_IDX);

   mode_t      r_mode;
   logic [7:0] r_val;
   logic [7:0] w_lfsr_seed;

   assign w_lfsr_seed = i_seed ^ IDX;

   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         r_mode <= MODE_UPDOWN;
         r_val  <= 8'h00;
      end else if (i_load) begin
         r_mode <= mode_t'(i_mode);
         case (mode_t'(i_mode))
            MODE_OFFSET: r_val <= i_seed + IDX;
            // An all-zero LFSR state would lock up
            MODE_LFSR:   r_val <= (w_lfsr_seed == 8'h00) ? 8'h01 : w_lfsr_seed;
            default:     r_val <= i_seed;
         endcase
      end else if (i_step) begin
         case (r_mode)
            MODE_UPDOWN: r_val <= IDX[0] ? (r_val - 8'd1) : (r_val + 8'd1);
            MODE_OFFSET: r_val <= r_val + 8'd1;
            MODE_LFSR:   r_val <= lfsr_next(r_val);
            default:     r_val <= r_val;
         endcase
      end
   end

   assign o_pattern = r_val;

endmodule

// File: rtl/mipi_dphy_ppi_pattern_gen.sv
// PPI-side HS burst source: SoT/data/EoT/gap framing on all lanes, one clock domain.
// MIPI_DPHY_PPI_PATTERN_GEN_ERR_INJ_EN enables SoT corruption through err_inject.
//
// state | meaning
// IDLE  | stop state, waiting for enable
// SOT   | one sync-byte cycle, config latched, lane generators loaded
// DATA  | burst_len payload cycles
// EOT   | one cycle with all lane flags low, burst counted
// GAP   | gap_len stop-state cycles before the next SOT or IDLE
module mipi_dphy_ppi_pattern_gen
   import mipi_dphy_ppi_pattern_pkg::*;
#(
   parameter int LANES     = 2,
   parameter int LEN_WIDTH = 16
)
(
   input  logic                 core_clk,
   input  logic                 core_rst,
   input  logic                 enable,
   input  logic [1:0]           cfg_mode,
   input  logic [LEN_WIDTH-1:0] cfg_burst_len,
   input  logic [LEN_WIDTH-1:0] cfg_gap_len,
   input  logic [7:0]           cfg_seed,
   input  logic                 err_inject,
   output logic [8*LANES-1:0]   dl_rxdatahs,
   output logic [LANES-1:0]     dl_rxvalidhs,
   output logic [LANES-1:0]     dl_rxactivehs,
   output logic [LANES-1:0]     dl_rxsynchs,
   output logic [LANES-1:0]     dl_stopstate,
   output logic [LANES-1:0]     dl_errsoths,
   output logic                 busy,
   output logic [15:0]          burst_count
);

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

   state_t               r_state;
   logic [LEN_WIDTH-1:0] r_burst_len;
   logic [LEN_WIDTH-1:0] r_gap_len;
   logic [LEN_WIDTH-1:0] r_cnt;
   logic [15:0]          r_burst_count;
   logic [8*LANES-1:0]   r_data;
   logic                 r_stop;
   logic                 r_active;
   logic                 r_valid;
   logic                 r_sync;
   logic                 r_errsot;
   logic                 r_busy;

   logic [8*LANES-1:0]   w_lane_data;
   logic                 w_go_sot;
   logic                 w_step;
   logic                 w_err_now;
   logic [7:0]           w_sot_byte;

   // SOT is entered from IDLE, from EOT with no gap, or from the last GAP cycle
   assign w_go_sot = enable && ((r_state == IDLE) ||
                                (r_state == EOT && r_gap_len == '0) ||
                                (r_state == GAP && r_cnt == '0));
   assign w_step   = (r_state == SOT) || (r_state == DATA && r_cnt != '0);

`ifdef MIPI_DPHY_PPI_PATTERN_GEN_ERR_INJ_EN
   logic r_err_arm;

   always_ff @(posedge core_clk) begin
      if (core_rst)        r_err_arm <= 1'b0;
      else if (w_go_sot)   r_err_arm <= 1'b0;
      else if (err_inject) r_err_arm <= 1'b1;
   end

   assign w_err_now = w_go_sot && (r_err_arm || err_inject);
`else
   logic w_err_unused;

   assign w_err_unused = err_inject;
   assign w_err_now    = 1'b0;
`endif

   assign w_sot_byte = w_err_now ? SYNC_BYTE_ERR : SYNC_BYTE;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      mipi_dphy_ppi_pattern_lane #(.LANE_IDX(k)) u_lane (
         .core_clk  (core_clk),
         .core_rst  (core_rst),
         .i_load    (w_go_sot),
         .i_step    (w_step),
         .i_mode    (cfg_mode),
         .i_seed    (cfg_seed),
         .o_pattern (w_lane_data[8*k +: 8])
      );
   end

   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         r_state       <= IDLE;
         r_burst_len   <= '0;
         r_gap_len     <= '0;
         r_cnt         <= '0;
         r_burst_count <= '0;
         r_data        <= '0;
         r_stop        <= 1'b1;
         r_active      <= 1'b0;
         r_valid       <= 1'b0;
         r_sync        <= 1'b0;
         r_errsot      <= 1'b0;
         r_busy        <= 1'b0;
      end else if (w_go_sot) begin
         r_state     <= SOT;
         r_burst_len <= (cfg_burst_len == '0) ? LEN_ONE : cfg_burst_len;
         r_gap_len   <= cfg_gap_len;
         r_data      <= {LANES{w_sot_byte}};
         r_stop      <= 1'b0;
         r_active    <= 1'b1;
         r_valid     <= 1'b1;
         r_sync      <= 1'b1;
         r_errsot    <= w_err_now;
         r_busy      <= 1'b1;
      end else begin
         case (r_state)
            SOT: begin
               r_state  <= DATA;
               r_cnt    <= r_burst_len - LEN_ONE;
               r_data   <= w_lane_data;
               r_sync   <= 1'b0;
               r_errsot <= 1'b0;
            end
            DATA: begin
               if (r_cnt == '0) begin
                  r_state       <= EOT;
                  r_data        <= '0;
                  r_active      <= 1'b0;
                  r_valid       <= 1'b0;
                  r_burst_count <= r_burst_count + 16'd1;
               end else begin
                  r_cnt  <= r_cnt - LEN_ONE;
                  r_data <= w_lane_data;
               end
            end
            EOT: begin
               r_stop <= 1'b1;
               if (r_gap_len == '0) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= GAP;
                  r_cnt   <= r_gap_len - LEN_ONE;
               end
            end
            GAP: begin
               if (r_cnt == '0) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - LEN_ONE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_stop  <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign dl_rxdatahs   = r_data;
   assign dl_rxvalidhs  = {LANES{r_valid}};
   assign dl_rxactivehs = {LANES{r_active}};
   assign dl_rxsynchs   = {LANES{r_sync}};
   assign dl_stopstate  = {LANES{r_stop}};
   assign dl_errsoths   = {LANES{r_errsot}};
   assign busy          = r_busy;
   assign burst_count   = r_burst_count;

endmodule

// File: tb/tb_mipi_dphy_ppi_pattern_gen.sv
// Bench for mipi_dphy_ppi_pattern_gen (4 lanes): a burst-level model builds per-cycle
// stimulus and expected PPI outputs, then every cycle is compared against the DUT.
module tb_mipi_dphy_ppi_pattern_gen;

   localparam int LANES = 4;
   localparam int LW    = 16;
`ifdef MIPI_DPHY_PPI_PATTERN_GEN_ERR_INJ_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   localparam int K_IDLE = 0;
   localparam int K_SOT  = 1;
   localparam int K_DATA = 2;
   localparam int K_EOT  = 3;
   localparam int K_GAP  = 4;

   logic                 core_clk = 1'b0;
   logic                 core_rst;
   logic                 enable;
   logic [1:0]           cfg_mode;
   logic [LW-1:0]        cfg_burst_len;
   logic [LW-1:0]        cfg_gap_len;
   logic [7:0]           cfg_seed;
   logic                 err_inject;
   logic [8*LANES-1:0]   dl_rxdatahs;
   logic [LANES-1:0]     dl_rxvalidhs;
   logic [LANES-1:0]     dl_rxactivehs;
   logic [LANES-1:0]     dl_rxsynchs;
   logic [LANES-1:0]     dl_stopstate;
   logic [LANES-1:0]     dl_errsoths;
   logic                 busy;
   logic [15:0]          burst_count;

   mipi_dphy_ppi_pattern_gen #(.LANES(LANES), .LEN_WIDTH(LW)) dut (
      .core_clk      (core_clk),
      .core_rst      (core_rst),
      .enable        (enable),
      .cfg_mode      (cfg_mode),
      .cfg_burst_len (cfg_burst_len),
      .cfg_gap_len   (cfg_gap_len),
      .cfg_seed      (cfg_seed),
      .err_inject    (err_inject),
      .dl_rxdatahs   (dl_rxdatahs),
      .dl_rxvalidhs  (dl_rxvalidhs),
      .dl_rxactivehs (dl_rxactivehs),
      .dl_rxsynchs   (dl_rxsynchs),
      .dl_stopstate  (dl_stopstate),
      .dl_errsoths   (dl_errsoths),
      .busy          (busy),
      .burst_count   (burst_count)
   );

   always #5 core_clk = ~core_clk;

   typedef struct {
      bit          rst;
      bit          en;
      bit          err;
      logic [1:0]  mode;
      logic [15:0] blen;
      logic [15:0] glen;
      logic [7:0]  seed;
   } stim_t;

   typedef struct {
      logic               stop;
      logic               active;
      logic               valid;
      logic               sync;
      logic               errsot;
      logic               busy;
      logic [8*LANES-1:0] data;
      logic [15:0]        cnt;
   } exp_t;

   stim_t sq[$];
   exp_t  eq[$];
   bit    m_arm;
   int    m_cnt;
   int    n_assert;
   int    n_fail;
   int    cyc;

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      logic [7:0] r;
      r = v >> 1;
      if (v[0]) r = r ^ 8'hB8;
      return r;
   endfunction

   // Byte i of lane k straight from the pattern definitions
   function automatic logic [7:0] pat(input int mode, input logic [7:0] seed, input int k, input int i);
      logic [7:0] v;
      case (mode)
         0: return (k % 2 == 0) ? seed + 8'(i) : seed - 8'(i);
         1: return seed + 8'(i) + 8'(k);
         2: return seed;
         default: begin
            v = seed ^ 8'(k);
            if (v == 8'h00) v = 8'h01;
            for (int j = 0; j < i; j++) v = lfsr_step(v);
            return v;
         end
      endcase
   endfunction

   function automatic bit rnd_err(input int pct);
      return ($urandom_range(0, 99) < pct);
   endfunction

   task automatic push(input bit rst, input bit en, input bit err, input int kind,
                       input logic [1:0] mode, input logic [15:0] blen, input logic [15:0] glen,
                       input logic [7:0] seed, input logic [8*LANES-1:0] data);
      stim_t s;
      exp_t  e;
      s.rst = rst; s.en = en; s.err = err; s.mode = mode;
      s.blen = blen; s.glen = glen; s.seed = seed;
      e.stop = 0; e.active = 0; e.valid = 0; e.sync = 0; e.errsot = 0; e.busy = 0; e.data = '0;
      if (rst) begin
         m_arm = 0;
         m_cnt = 0;
         e.stop = 1;
      end else if (kind == K_SOT) begin
         e.errsot = ERR_EN && (m_arm || err);
         m_arm    = 0;
         e.active = 1; e.valid = 1; e.sync = 1; e.busy = 1;
         e.data   = {LANES{(e.errsot ? 8'hB9 : 8'hB8)}};
      end else begin
         if (ERR_EN && err) m_arm = 1;
         case (kind)
            K_DATA: begin e.active = 1; e.valid = 1; e.busy = 1; e.data = data; end
            K_EOT:  begin e.busy = 1; m_cnt = m_cnt + 1; end
            K_GAP:  begin e.stop = 1; e.busy = 1; end
            default: e.stop = 1;
         endcase
      end
      e.cnt = 16'(m_cnt);
      sq.push_back(s);
      eq.push_back(e);
   endtask

   task automatic push_rnd(input bit rst, input bit en, input bit err, input int kind,
                           input logic [8*LANES-1:0] data);
      push(rst, en, err, kind, 2'($urandom), 16'($urandom), 16'($urandom), 8'($urandom), data);
   endtask

   task automatic add_idle(input int n, input int err_pct);
      for (int i = 0; i < n; i++) push_rnd(0, 0, rnd_err(err_pct), K_IDLE, '0);
   endtask

   // One framed burst; last ends in IDLE, abort>=0 resets before that data byte,
   // err_at pulses err_inject at that stimulus index (0 = SOT cycle)
   task automatic add_burst(input int mode, input int blen, input int glen, input int seed,
                            input bit last, input int abort, input int err_at, input int err_pct);
      int                 eff;
      int                 idx;
      logic [8*LANES-1:0] d;
      eff = (blen == 0) ? 1 : blen;
      idx = 0;
      push(0, 1, (err_at == idx) || rnd_err(err_pct), K_SOT, 2'(mode), 16'(blen), 16'(glen), 8'(seed), '0);
      for (int i = 0; i < eff; i++) begin
         idx++;
         if (abort == i) begin
            push_rnd(1, 1'($urandom), 1'($urandom), K_IDLE, '0);
            return;
         end
         for (int k = 0; k < LANES; k++) d[8*k +: 8] = pat(mode, 8'(seed), k, i);
         push_rnd(0, last ? 1'b0 : 1'($urandom), (err_at == idx) || rnd_err(err_pct), K_DATA, d);
      end
      idx++;
      push_rnd(0, last ? 1'b0 : 1'($urandom), (err_at == idx) || rnd_err(err_pct), K_EOT, '0);
      for (int g = 0; g < glen; g++) begin
         idx++;
         push_rnd(0, last ? 1'b0 : 1'($urandom), (err_at == idx) || rnd_err(err_pct), K_GAP, '0);
      end
      if (last) push_rnd(0, 0, 0, K_IDLE, '0);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp_v);
      end
   endtask

   task automatic play();
      stim_t s;
      exp_t  e;
      while (sq.size() > 0) begin
         s = sq.pop_front();
         e = eq.pop_front();
         core_rst      = s.rst;
         enable        = s.en;
         err_inject    = s.err;
         cfg_mode      = s.mode;
         cfg_burst_len = s.blen;
         cfg_gap_len   = s.glen;
         cfg_seed      = s.seed;
         @(posedge core_clk);
         #1;
         cyc++;
         chk("stopstate", 64'(dl_stopstate),  64'({LANES{e.stop}}));
         chk("activehs",  64'(dl_rxactivehs), 64'({LANES{e.active}}));
         chk("validhs",   64'(dl_rxvalidhs),  64'({LANES{e.valid}}));
         chk("synchs",    64'(dl_rxsynchs),   64'({LANES{e.sync}}));
         chk("errsoths",  64'(dl_errsoths),   64'({LANES{e.errsot}}));
         chk("busy",      64'(busy),          64'(e.busy));
         chk("datahs",    64'(dl_rxdatahs),   64'(e.data));
         chk("burst_cnt", 64'(burst_count),   64'(e.cnt));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_assert = 0; n_fail = 0; cyc = 0; m_arm = 0; m_cnt = 0;
      core_rst = 1; enable = 0; err_inject = 0; cfg_mode = 0;
      cfg_burst_len = 0; cfg_gap_len = 0; cfg_seed = 0;

      push_rnd(1, 1'($urandom), 0, K_IDLE, '0);
      push_rnd(1, 1'($urandom), 0, K_IDLE, '0);
      add_idle(2, 0);
      // up/down counter, back-to-back, 8-cycle period
      add_burst(0, 4, 2, 8'h10, 0, -1, -1, 0);
      add_burst(0, 4, 2, 8'h10, 1, -1, -1, 0);
      // lane-offset counter wrapping past 0xFF
      add_burst(1, 3, 1, 8'hFE, 1, -1, -1, 0);
      // long LFSR burst, zero seed on lane 0
      add_burst(3, 300, 0, 8'h00, 1, -1, -1, 0);
      // enable low from the first data byte on: burst still completes
      push_rnd(1, 0, 0, K_IDLE, '0);
      add_burst(0, 8, 3, 8'h5A, 1, -1, -1, 0);
      // minimal bursts with no gap
      add_burst(2, 0, 0, 8'h33, 0, -1, -1, 0);
      add_burst(0, 0, 0, 8'h80, 0, -1, -1, 0);
      add_burst(1, 0, 0, 8'hFF, 0, -1, -1, 0);
      add_burst(3, 0, 0, 8'h02, 1, -1, -1, 0);
      // error pulse in the first gap cycle corrupts only the next SOT
      add_burst(2, 2, 2, 8'hC3, 0, -1, 4, 0);
      add_burst(2, 2, 2, 8'hC3, 0, -1, -1, 0);
      add_burst(2, 2, 0, 8'h3C, 1, -1, -1, 0);
      // error armed, then reset mid-data: the following SOT is clean
      add_burst(0, 6, 1, 8'h20, 0, 2, 1, 0);
      add_idle(1, 0);
      add_burst(1, 2, 1, 8'h40, 1, -1, -1, 0);
      add_idle(2, 0);
      for (int b = 0; b < 25; b++) begin
         add_burst($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 3),
                   $urandom_range(0, 255), ($urandom_range(0, 3) == 0), -1, -1, 15);
         if (sq.size() > 0 && !sq[sq.size()-1].en) add_idle($urandom_range(0, 2), 10);
      end
      add_burst($urandom_range(0, 3), $urandom_range(1, 5), 1, $urandom_range(0, 255), 1, -1, -1, 0);
      add_idle(2, 0);

      play();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
